// File: rtl/ripple_rate_if.sv
// Button inputs and step-control outputs shared by ripple_rate_ctrl and its consumer.
// The master side is the rate controller. The slave side is the ripple stage or the bench.
interface ripple_rate_if;
   logic       btn_speed;
   logic       btn_pause;
   logic       btn_dir;
   logic       tick;
   logic       dir;
   logic [1:0] speed;
   logic       paused;

   modport master (
      input  btn_speed, btn_pause, btn_dir,
      output tick, dir, speed, paused
   );

   modport slave (
      output btn_speed, btn_pause, btn_dir,
      input  tick, dir, speed, paused
   );
endinterface

// File: rtl/ripple_rate_ctrl.sv
// Conditions the speed/pause/dir buttons and produces the programmable-rate step tick
// for the rippling LED chain.
module ripple_rate_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int BASE_DIV        = 8,
   parameter int CNT_W           = $clog2(BASE_DIV * 8)
) (
   input  logic          clk,
   input  logic          rst_n,
   ripple_rate_if.master bus
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   // Bit order for all per-button vectors: 0 = speed, 1 = pause, 2 = dir.
   logic [2:0]       btn_raw;
   logic [2:0]       sync1_q, sync1_d;
   logic [2:0]       sync2_q, sync2_d;
   logic [2:0]       deb_q, deb_d;
   logic [2:0]       press_q, press_d;
   logic [DB_W-1:0]  db_cnt_q [3];
   logic [DB_W-1:0]  db_cnt_d [3];

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] term;
   logic             tc;
   logic             tick_q, tick_d;
   logic             dir_q, dir_d;
   logic             paused_q, paused_d;
   logic [1:0]       speed_q, speed_d;

   assign btn_raw = {bus.btn_dir, bus.btn_pause, bus.btn_speed};

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      for (int b = 0; b < 3; b++) begin
         db_cnt_d[b] = '0;
         if (sync2_q[b] != deb_q[b]) begin
            if (db_cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1))
               deb_d[b] = sync2_q[b];
            else
               db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
         end
      end
      // Only the accepted rising edge of a debounced level counts as a press.
      press_d = deb_d & ~deb_q;
   end

   always_comb begin
      term     = CNT_W'((BASE_DIV << speed_q) - 1);
      tc       = ~paused_q & (cnt_q == term);
      tick_d   = tc;
      cnt_d    = cnt_q;
      speed_d  = speed_q;
      paused_d = paused_q;
      dir_d    = dir_q;
      if (!paused_q)
         cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
      // A speed press restarts the period but never swallows a tick already due.
      if (press_q[0]) begin
         speed_d = speed_q + 2'd1;
         cnt_d   = '0;
      end
      if (press_q[1])
         paused_d = ~paused_q;
      if (press_q[2])
         dir_d = ~dir_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         deb_q    <= '0;
         press_q  <= '0;
         for (int b = 0; b < 3; b++)
            db_cnt_q[b] <= '0;
         cnt_q    <= '0;
         tick_q   <= 1'b0;
         dir_q    <= 1'b0;
         paused_q <= 1'b0;
         speed_q  <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         deb_q    <= deb_d;
         press_q  <= press_d;
         for (int b = 0; b < 3; b++)
            db_cnt_q[b] <= db_cnt_d[b];
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
         dir_q    <= dir_d;
         paused_q <= paused_d;
         speed_q  <= speed_d;
      end
   end

   assign bus.tick   = tick_q;
   assign bus.dir    = dir_q;
   assign bus.speed  = speed_q;
   assign bus.paused = paused_q;

endmodule

// File: tb/tb_ripple_rate_ctrl.sv
// Directed bench for ripple_rate_ctrl with a per-cycle reference model and literal checkpoints.
module tb_ripple_rate_ctrl;
   localparam int DB = 4;
   localparam int BD = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   ripple_rate_if bus ();

   ripple_rate_ctrl #(.DEBOUNCE_CYCLES(DB), .BASE_DIV(BD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model. The divider is tracked as "unpaused cycles left until the next tick".
   logic       started = 1'b0;
   logic       m_tick = 1'b0, m_dir = 1'b0, m_paused = 1'b0;
   logic [1:0] m_speed = 2'd0;
   int         m_rem = BD;
   logic [2:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_ev = '0;
   int         m_run [3] = '{0, 0, 0};

   always @(posedge clk) begin : model
      logic [2:0] ev_new;
      logic [2:0] raw;
      raw = {bus.btn_dir, bus.btn_pause, bus.btn_speed};
      if (!rst_n) begin
         started  = 1'b1;
         m_tick   = 1'b0;
         m_dir    = 1'b0;
         m_paused = 1'b0;
         m_speed  = 2'd0;
         m_rem    = BD;
         m_s1     = '0;
         m_s2     = '0;
         m_deb    = '0;
         m_ev     = '0;
         for (int b = 0; b < 3; b++) m_run[b] = 0;
      end else begin
         m_tick = !m_paused && (m_rem == 1);
         if (!m_paused) m_rem = (m_rem == 1) ? (BD << m_speed) : m_rem - 1;
         if (m_ev[0]) begin
            m_speed = m_speed + 2'd1;
            m_rem   = BD << m_speed;
         end
         if (m_ev[1]) m_paused = !m_paused;
         if (m_ev[2]) m_dir = !m_dir;
         ev_new = '0;
         for (int b = 0; b < 3; b++) begin
            if (m_s2[b] != m_deb[b]) begin
               m_run[b]++;
               if (m_run[b] == DB) begin
                  m_deb[b]  = m_s2[b];
                  m_run[b]  = 0;
                  ev_new[b] = m_s2[b];
               end
            end else begin
               m_run[b] = 0;
            end
         end
         m_ev = ev_new;
         m_s2 = m_s1;
         m_s1 = raw;
      end
   end

   always @(negedge clk) begin
      if (started)
         check("outputs{tick,dir,speed,paused}",
               {27'd0, bus.tick, bus.dir, bus.speed, bus.paused},
               {27'd0, m_tick, m_dir, m_speed, m_paused});
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic measure_period(output int p);
      int g;
      g = 0;
      while (!bus.tick && g < 100) begin
         @(negedge clk);
         g++;
      end
      p = 0;
      do begin
         @(negedge clk);
         p++;
      end while (!bus.tick && p < 100);
   endtask

   task automatic press_btn(input int which);
      if (which == 0) bus.btn_speed = 1'b1;
      else if (which == 1) bus.btn_pause = 1'b1;
      else bus.btn_dir = 1'b1;
      cyc(8);
      bus.btn_speed = 1'b0;
      bus.btn_pause = 1'b0;
      bus.btn_dir   = 1'b0;
      cyc(10);
   endtask

   initial begin
      int k, p, ticks;
      logic old_dir;
      bus.btn_speed = 1'b0;
      bus.btn_pause = 1'b0;
      bus.btn_dir   = 1'b0;
      rst_n = 1'b0;
      cyc(3);
      check("reset_outputs", {28'd0, bus.tick, bus.dir, bus.speed}, 32'd0);
      check("reset_paused", {31'd0, bus.paused}, 32'd0);
      rst_n = 1'b1;

      // Idle: period 4.
      ticks = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.tick) ticks++;
      end
      check("idle_tick_count", ticks, 10);

      // Speed press latency and period per speed.
      bus.btn_speed = 1'b1;
      k = 0;
      while (bus.speed == 2'd0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("speed_latency", k, 7);
      check("speed_after_press", {30'd0, bus.speed}, 32'd1);
      check("model_speed_after_press", {30'd0, m_speed}, 32'd1);
      cyc(3);
      bus.btn_speed = 1'b0;
      cyc(10);
      measure_period(p);
      check("period_speed1", p, 8);
      press_btn(0);
      measure_period(p);
      check("period_speed2", p, 16);
      press_btn(0);
      measure_period(p);
      check("period_speed3", p, 32);
      press_btn(0);
      check("speed_wrap", {30'd0, bus.speed}, 32'd0);
      measure_period(p);
      check("period_speed0", p, 4);

      // Direction: short glitch ignored, proper press toggles.
      bus.btn_dir = 1'b1;
      cyc(3);
      bus.btn_dir = 1'b0;
      cyc(12);
      check("dir_glitch", {31'd0, bus.dir}, 32'd0);
      bus.btn_dir = 1'b1;
      k = 0;
      while (bus.dir == 1'b0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("dir_latency", k, 7);
      bus.btn_dir = 1'b0;
      cyc(10);
      measure_period(p);
      check("period_after_dir", p, 4);

      // Pause freezes the divider, resume keeps the remaining count.
      k = 0;
      while (!bus.tick && k < 20) begin
         @(negedge clk);
         k++;
      end
      bus.btn_pause = 1'b1;
      k = 0;
      while (!bus.paused && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("pause_latency", k, 7);
      ticks = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (i == 1) bus.btn_pause = 1'b0;
         if (bus.tick) ticks++;
      end
      check("ticks_while_paused", ticks, 0);
      bus.btn_pause = 1'b1;
      k = 0;
      while (bus.paused && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("unpause_latency", k, 7);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.tick && k < 50);
      check("first_tick_after_unpause", k, 1);
      bus.btn_pause = 1'b0;
      cyc(10);

      // Simultaneous speed and dir presses land on the same edge.
      old_dir = bus.dir;
      bus.btn_speed = 1'b1;
      bus.btn_dir   = 1'b1;
      k = 0;
      while (bus.speed == 2'd0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("simul_latency", k, 7);
      check("simul_speed", {30'd0, bus.speed}, 32'd1);
      check("simul_dir", {31'd0, bus.dir}, {31'd0, ~old_dir});
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.tick && k < 50);
      check("simul_next_tick", k, 8);
      bus.btn_speed = 1'b0;
      bus.btn_dir   = 1'b0;
      cyc(10);

      // Reset mid-debounce while paused at speed 2.
      press_btn(0);
      press_btn(1);
      check("pre_reset_speed", {30'd0, bus.speed}, 32'd2);
      check("pre_reset_paused", {31'd0, bus.paused}, 32'd1);
      bus.btn_dir = 1'b1;
      cyc(4);
      rst_n = 1'b0;
      bus.btn_dir = 1'b0;
      @(negedge clk);
      check("midrun_reset_outputs",
            {27'd0, bus.tick, bus.dir, bus.speed, bus.paused}, 32'd0);
      rst_n = 1'b1;
      measure_period(p);
      check("period_after_reset", p, 4);
      cyc(10);
      check("dir_after_reset", {31'd0, bus.dir}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
